// File: rtl/bin2bcd_seq_if.sv
// rtl/bin2bcd_seq_if.sv - request/result bundle between the counter stage and the BCD converter
interface bin2bcd_seq_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);
  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;

  // Requester side: issues conversions, reads back the digits
  modport master (
    output start,
    output bin,
    input  busy,
    input  done,
    input  bcd
  );

  // Converter side
  modport slave (
    input  start,
    input  bin,
    output busy,
    output done,
    output bcd
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary to BCD converter, one bit per clock
module bin2bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic         clock_100Mhz,
  input  logic         reset_n,
  bin2bcd_seq_if.slave bus
);

  localparam int BW = 4 * DIGITS;
  localparam int SW = BW + WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t          r_state;
  logic [SW-1:0]   r_sreg;   // {BCD scratch, binary bits still to shift}
  logic [CW-1:0]   r_cnt;
  logic            r_busy;
  logic            r_done;
  logic [BW-1:0]   r_bcd;

  logic [SW-1:0]   w_adj;
  logic [SW-1:0]   w_shift;

  // Add-3 correction on every BCD nibble from current values, then shift left by one
  always_comb begin
    w_adj = r_sreg;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_sreg[WIDTH + 4*d +: 4] >= 4'd5) begin
        w_adj[WIDTH + 4*d +: 4] = r_sreg[WIDTH + 4*d +: 4] + 4'd3;
      end
    end
    w_shift = {w_adj[SW-2:0], 1'b0};
  end

  // Control FSM; bcd is only written on the completion edge so it never shows partial digits
  always_ff @(posedge clock_100Mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_sreg  <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_bcd   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_sreg  <= {{BW{1'b0}}, bus.bin};
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_sreg <= w_shift;
          r_cnt  <= r_cnt + CW'(1);
          if (r_cnt == LAST_CNT) begin
            r_bcd   <= w_shift[SW-1 -: BW];
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.bcd  = r_bcd;

endmodule
